// File: rtl/fft_word_serializer.sv
// Captures an N-word vector in one transfer and streams it one word per beat, natural or bit-reversed order.
// Latency: first word is presented the cycle after acceptance; back-to-back vectors stream without a bubble.
// Backpressure: out_ready low freezes the current word; a new vector is taken only when idle or on the final beat.
module fft_word_serializer #(
    parameter  int WIDTH = 32,
    parameter  int N     = 8,
    localparam int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic                 bitrev,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_index,
    output logic                 out_last,
    output logic                 busy
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [SELW-1:0] CNT_LAST = SELW'(N - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [N-1:0][WIDTH-1:0] bank;
    logic [SELW-1:0]         cnt;
    logic [SELW-1:0]         cnt_rev;
    logic [SELW-1:0]         sel;
    logic                    mode;
    logic                    is_send;
    logic                    at_last;
    logic                    final_beat;
    logic                    accept;

    always_comb begin
        cnt_rev = '0;
        for (int i = 0; i < SELW; i++) begin
            cnt_rev[i] = cnt[SELW-1-i];
        end
        sel = mode ? cnt_rev : cnt;
    end

    // Handshake terms; in_ready sees out_ready so a reload lands on the final beat.
    always_comb begin
        is_send    = (state == SEND);
        at_last    = (cnt == CNT_LAST);
        final_beat = is_send && at_last && out_ready;
        in_ready   = !is_send || final_beat;
        accept     = in_valid && in_ready;
    end

    always_comb begin
        out_valid = is_send;
        busy      = is_send;
        out_last  = is_send && at_last;
        out_index = is_send ? sel : '0;
        out_data  = is_send ? bank[sel] : '0;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (final_beat) begin
                    state_nxt = accept ? SEND : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank <= '0;
            cnt  <= '0;
            mode <= 1'b0;
        end else if (accept) begin
            bank <= in_data;
            mode <= bitrev;
            cnt  <= '0;
        end else if (is_send && out_ready) begin
            cnt <= at_last ? '0 : cnt + SELW'(1);
        end
    end

endmodule

// File: tb/tb_fft_word_serializer.sv
// Directed bench: vector table for order modes, hand sequences for stall, reload, reset and small N.
module tb_fft_word_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // N=8, WIDTH=32
    logic         iv8, ir8, br8, ov8, or8, ol8, bz8;
    logic [255:0] id8;
    logic [31:0]  od8;
    logic [2:0]   oi8;
    // N=4, WIDTH=16
    logic         iv4, ir4, br4, ov4, or4, ol4, bz4;
    logic [63:0]  id4;
    logic [15:0]  od4;
    logic [1:0]   oi4;
    // N=2, WIDTH=8
    logic         iv2, ir2, br2, ov2, or2, ol2, bz2;
    logic [15:0]  id2;
    logic [7:0]   od2;
    logic [0:0]   oi2;

    fft_word_serializer #(.WIDTH(32), .N(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_data(id8), .bitrev(br8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_index(oi8), .out_last(ol8), .busy(bz8));
    fft_word_serializer #(.WIDTH(16), .N(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_data(id4), .bitrev(br4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_index(oi4), .out_last(ol4), .busy(bz4));
    fft_word_serializer #(.WIDTH(8), .N(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_data(id2), .bitrev(br2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_index(oi2), .out_last(ol2), .busy(bz2));

    typedef struct packed {
        logic            br;
        logic [31:0]     base;
        logic [7:0][2:0] idx;
    } vrec_t;

    vrec_t tbl [3];
    int    n_chk = 0;
    int    n_pass = 0;
    int    k;
    int    bp [10];
    int    e4 [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [255:0] fill8(input logic [31:0] base);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = base + 32'(i);
        return v;
    endfunction

    function automatic logic [63:0] fill4(input logic [15:0] base);
        logic [63:0] v;
        for (int i = 0; i < 4; i++) v[i*16 +: 16] = base + 16'(i);
        return v;
    endfunction

    function automatic logic [15:0] fill2(input logic [7:0] base);
        logic [15:0] v;
        for (int i = 0; i < 2; i++) v[i*8 +: 8] = base + 8'(i);
        return v;
    endfunction

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b0, 32'hA0000000, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
        tbl[1] = '{1'b1, 32'hA0000000, {3'd7, 3'd3, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4, 3'd0}};
        tbl[2] = '{1'b0, 32'h5A5A0F00, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
        bp = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1};
        e4 = '{0, 2, 1, 3};
        iv8 = 0; id8 = '0; br8 = 0; or8 = 1;
        iv4 = 0; id4 = '0; br4 = 0; or4 = 1;
        iv2 = 0; id2 = '0; br2 = 0; or2 = 1;

        #12;
        chk("rst_out_valid", ov8, 0);
        chk("rst_out_data", od8, 0);
        chk("rst_out_index", oi8, 0);
        chk("rst_out_last", ol8, 0);
        chk("rst_busy", bz8, 0);
        chk("rst_in_ready", ir8, 1);
        rst_n = 1;
        @(posedge clk); #1;

        // Table: natural, bit-reversed (bitrev toggled mid-vector), second natural pattern
        for (int t = 0; t < 3; t++) begin
            iv8 = 1; id8 = fill8(tbl[t].base); br8 = tbl[t].br;
            @(posedge clk); #1;
            iv8 = 0; id8 = '1; br8 = ~tbl[t].br;
            for (int b = 0; b < 8; b++) begin
                @(negedge clk);
                chk("vec_valid", ov8, 1);
                chk("vec_index", oi8, tbl[t].idx[b]);
                chk("vec_data", od8, tbl[t].base + 32'(tbl[t].idx[b]));
                chk("vec_last", ol8, b == 7);
                chk("vec_in_ready", ir8, b == 7);
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk("vec_end_busy", bz8, 0);
            chk("vec_end_in_ready", ir8, 1);
            chk("vec_end_valid", ov8, 0);
            chk("vec_end_last", ol8, 0);
            @(posedge clk); #1;
        end

        // Backpressure: stalls freeze the word, every word once, in order
        br8 = 0; iv8 = 1; id8 = fill8(32'hD0000000);
        @(posedge clk); #1;
        iv8 = 0;
        k = 0;
        for (int c = 0; c < 20 && k < 8; c++) begin
            or8 = (c < 10) ? (bp[c] != 0) : 1'b1;
            @(negedge clk);
            chk("bp_valid", ov8, 1);
            chk("bp_index", oi8, k);
            chk("bp_data", od8, 32'hD0000000 + 32'(k));
            chk("bp_last", ol8, k == 7);
            @(posedge clk); #1;
            if (or8) k++;
        end
        chk("bp_delivered", k, 8);
        or8 = 1;
        @(negedge clk);
        chk("bp_idle", ov8, 0);
        @(posedge clk); #1;

        // Back-to-back: B follows A with no bubble
        iv8 = 1; id8 = fill8(32'hA0000000); br8 = 0;
        @(posedge clk); #1;
        id8 = fill8(32'hB0000000);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk("b2b_valid", ov8, 1);
            chk("b2b_index", oi8, c % 8);
            chk("b2b_data", od8, ((c < 8) ? 32'hA0000000 : 32'hB0000000) + 32'(c % 8));
            chk("b2b_in_ready", ir8, (c == 7) || (c == 15));
            chk("b2b_last", ol8, (c % 8) == 7);
            @(posedge clk); #1;
            if (c == 7) iv8 = 0;
        end
        @(negedge clk);
        chk("b2b_idle", ov8, 0);
        @(posedge clk); #1;

        // Reset mid-vector
        iv8 = 1; id8 = fill8(32'hE0000000); br8 = 0;
        @(posedge clk); #1;
        iv8 = 0;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            chk("pre_rst_index", oi8, b);
            @(posedge clk); #1;
        end
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_valid", ov8, 0);
        chk("mid_rst_data", od8, 0);
        chk("mid_rst_in_ready", ir8, 1);
        chk("mid_rst_busy", bz8, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_idle", ov8, 0);
        @(posedge clk); #1;
        iv8 = 1; id8 = fill8(32'hF0000000);
        @(posedge clk); #1;
        iv8 = 0;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            chk("post_rst_index", oi8, b);
            chk("post_rst_data", od8, 32'hF0000000 + 32'(b));
            @(posedge clk); #1;
        end
        for (int b = 2; b < 8; b++) begin
            @(posedge clk); #1;
        end

        // N=4, WIDTH=16, bit-reversed
        iv4 = 1; id4 = fill4(16'hC000); br4 = 1;
        @(posedge clk); #1;
        iv4 = 0; br4 = 0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk("n4_valid", ov4, 1);
            chk("n4_index", oi4, e4[b]);
            chk("n4_data", od4, 16'hC000 + 16'(e4[b]));
            chk("n4_last", ol4, b == 3);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("n4_idle", ov4, 0);
        @(posedge clk); #1;

        // N=2, WIDTH=8, both modes
        for (int m = 0; m < 2; m++) begin
            iv2 = 1; id2 = fill2(8'h30); br2 = (m == 1);
            @(posedge clk); #1;
            iv2 = 0;
            for (int b = 0; b < 2; b++) begin
                @(negedge clk);
                chk("n2_valid", ov2, 1);
                chk("n2_index", oi2, b);
                chk("n2_data", od2, 8'h30 + 8'(b));
                chk("n2_last", ol2, b == 1);
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk("n2_idle", ov2, 0);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
